// File: rtl/tdm_demux4.sv
// Serial TDM demultiplexer: reassembles 4-slot frames from a 1-bit stream into a parallel word.
// Optional DEMUX_PARITY_EN adds a fifth even-parity slot and drives par_err.
module tdm_demux4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic [3:0] q,
  output logic       q_valid,
`ifdef DEMUX_PARITY_EN
  output logic [2:0] slot,
`else
  output logic [1:0] slot,
`endif
  output logic       frame_err,
  output logic       par_err
);

`ifdef DEMUX_PARITY_EN
  localparam int SW = 3;
  localparam logic [SW-1:0] LAST_SLOT = 3'd4;
`else
  localparam int SW = 2;
  localparam logic [SW-1:0] LAST_SLOT = 2'd3;
`endif

  typedef enum logic {HUNT, RUN} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   slot_n;
  logic [3:0]      shadow, shadow_n;
  logic [3:0]      word, word_n;
  logic [3:0]      q_n;
  logic            pend_ok, pend_ok_n;
  logic            q_valid_n, frame_err_n;
`ifdef DEMUX_PARITY_EN
  logic            pend_par, pend_par_n;
`endif

  // A completed frame is parked in word/pend_ok for one cycle so q and the
  // pulses land one clock after the last-slot edge, leaving shadow free for
  // a back-to-back slot-0 capture on that same edge.
  always_comb begin
    state_n     = state;
    slot_n      = slot;
    shadow_n    = shadow;
    word_n      = word;
    pend_ok_n   = 1'b0;
    frame_err_n = 1'b0;
    q_valid_n   = pend_ok;
    q_n         = pend_ok ? word : q;
`ifdef DEMUX_PARITY_EN
    pend_par_n  = 1'b0;
`endif
    if (din_valid) begin
      if (state == HUNT) begin
        if (sync) begin
          shadow_n[0] = din;
          slot_n      = SW'(1);
          state_n     = RUN;
        end
      end else if (sync && (slot != '0)) begin
        // Misaligned sync: drop the partial frame and realign on this bit.
        frame_err_n = 1'b1;
        shadow_n[0] = din;
        slot_n      = SW'(1);
      end else if (slot == LAST_SLOT) begin
        slot_n = '0;
`ifdef DEMUX_PARITY_EN
        if ((^shadow) == din) begin
          word_n    = shadow;
          pend_ok_n = 1'b1;
        end else begin
          pend_par_n = 1'b1;
        end
`else
        shadow_n[3] = din;
        word_n      = shadow_n;
        pend_ok_n   = 1'b1;
`endif
      end else begin
        shadow_n[slot[1:0]] = din;
        slot_n              = slot + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      slot      <= '0;
      shadow    <= '0;
      word      <= '0;
      pend_ok   <= 1'b0;
      q         <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      shadow    <= shadow_n;
      word      <= word_n;
      pend_ok   <= pend_ok_n;
      q         <= q_n;
      q_valid   <= q_valid_n;
      frame_err <= frame_err_n;
    end
  end

`ifdef DEMUX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_par <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      pend_par <= pend_par_n;
      par_err  <= pend_par;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4; inputs change 1 time unit after
// each rising edge and outputs are sampled there too.
module tb_tdm_demux4;

`ifdef DEMUX_PARITY_EN
  localparam int SW = 3;
`else
  localparam int SW = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic          din_valid;
  logic          sync;
  logic [3:0]    q;
  logic          q_valid;
  logic [SW-1:0] slot;
  logic          frame_err;
  logic          par_err;

  int checks   = 0;
  int failures = 0;
  int qv_cnt   = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;

  tdm_demux4 dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .q(q), .q_valid(q_valid), .slot(slot), .frame_err(frame_err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (q_valid)   qv_cnt++;
    if (frame_err) fe_cnt++;
    if (par_err)   pe_cnt++;
  endtask

  task automatic send(input logic s, input logic d);
    sync = s; din = d; din_valid = 1'b1;
    tick();
    sync = 1'b0; din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0; sync = 1'b0;
    repeat (n) tick();
  endtask

  // Bits 1..3 of a word, then its even-parity bit when parity is built in.
  task automatic send_tail(input logic [3:0] w);
    send(1'b0, w[1]);
    send(1'b0, w[2]);
    send(1'b0, w[3]);
`ifdef DEMUX_PARITY_EN
    send(1'b0, ^w);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
    repeat (2) tick();
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL reset_q: got %b exp 0000", q); end
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL reset_q_valid: got %b exp 0", q_valid); end
    checks++; if (slot !== SW'(0)) begin failures++; $display("FAIL reset_slot: got %0d exp 0", slot); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
    checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL reset_par_err: got %b exp 0", par_err); end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    int qv0;
    qv0 = qv_cnt;
    send(1'b1, 1'b1);
    checks++; if (slot !== SW'(1)) begin failures++; $display("FAIL basic_slot1: got %0d exp 1", slot); end
    send(1'b0, 1'b0);
    checks++; if (slot !== SW'(2)) begin failures++; $display("FAIL basic_slot2: got %0d exp 2", slot); end
    send(1'b0, 1'b1);
    checks++; if (slot !== SW'(3)) begin failures++; $display("FAIL basic_slot3: got %0d exp 3", slot); end
    send(1'b0, 1'b1);
`ifdef DEMUX_PARITY_EN
    send(1'b0, 1'b1);
`endif
    checks++; if (slot !== SW'(0)) begin failures++; $display("FAIL basic_slot_wrap: got %0d exp 0", slot); end
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL basic_qv_early: got %b exp 0", q_valid); end
    idle(1);
    checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL basic_qv_pulse: got %b exp 1", q_valid); end
    checks++; if (q !== 4'b1101) begin failures++; $display("FAIL basic_q: got %b exp 1101", q); end
    idle(1);
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL basic_qv_end: got %b exp 0", q_valid); end
    checks++; if (q !== 4'b1101) begin failures++; $display("FAIL basic_q_hold: got %b exp 1101", q); end
    checks++; if (qv_cnt - qv0 !== 1) begin failures++; $display("FAIL basic_qv_count: got %0d exp 1", qv_cnt - qv0); end
  endtask

  task automatic test_gap();
    int qv0, fe0;
    qv0 = qv_cnt; fe0 = fe_cnt;
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    idle(3);
    checks++; if (slot !== SW'(2)) begin failures++; $display("FAIL gap_slot_hold: got %0d exp 2", slot); end
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
`ifdef DEMUX_PARITY_EN
    send(1'b0, 1'b0);
`endif
    idle(3);
    checks++; if (q !== 4'b0011) begin failures++; $display("FAIL gap_q: got %b exp 0011", q); end
    checks++; if (qv_cnt - qv0 !== 1) begin failures++; $display("FAIL gap_qv_count: got %0d exp 1", qv_cnt - qv0); end
    checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL gap_fe_count: got %0d exp 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err();
    int qv0, fe0;
    qv0 = qv_cnt; fe0 = fe_cnt;
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_pulse: got %b exp 1", frame_err); end
    checks++; if (slot !== SW'(1)) begin failures++; $display("FAIL ferr_slot: got %0d exp 1", slot); end
    checks++; if (q !== 4'b0011) begin failures++; $display("FAIL ferr_q_kept: got %b exp 0011", q); end
    send(1'b0, 1'b1);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_one_cycle: got %b exp 0", frame_err); end
    send(1'b0, 1'b1);
    send(1'b0, 1'b1);
`ifdef DEMUX_PARITY_EN
    send(1'b0, 1'b1);
`endif
    idle(2);
    checks++; if (q !== 4'b1110) begin failures++; $display("FAIL ferr_next_q: got %b exp 1110", q); end
    checks++; if (qv_cnt - qv0 !== 1) begin failures++; $display("FAIL ferr_qv_count: got %0d exp 1", qv_cnt - qv0); end
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL ferr_count: got %0d exp 1", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    send(1'b0, 1'b0);
    send_tail(4'b0110);
    send(1'b0, 1'b1);
    checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL b2b_qv: got %b exp 1", q_valid); end
    checks++; if (q !== 4'b0110) begin failures++; $display("FAIL b2b_q_first: got %b exp 0110", q); end
    checks++; if (slot !== SW'(1)) begin failures++; $display("FAIL b2b_slot: got %0d exp 1", slot); end
    send_tail(4'b1001);
    idle(1);
    checks++; if (q !== 4'b1001) begin failures++; $display("FAIL b2b_q_second: got %b exp 1001", q); end
    checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL b2b_qv_second: got %b exp 1", q_valid); end
    idle(1);
  endtask

  task automatic test_async_reset();
    int qv0;
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    checks++; if (slot !== SW'(2)) begin failures++; $display("FAIL arst_pre_slot: got %0d exp 2", slot); end
    qv0 = qv_cnt;
    #2 rst = 1'b1;
    #1;
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL arst_q: got %b exp 0000", q); end
    checks++; if (slot !== SW'(0)) begin failures++; $display("FAIL arst_slot: got %0d exp 0", slot); end
    checks++; if ({q_valid, frame_err, par_err} !== 3'b000) begin failures++; $display("FAIL arst_pulses: got %b exp 000", {q_valid, frame_err, par_err}); end
    tick();
    rst = 1'b0;
    repeat (3) send(1'b0, 1'b1);
    checks++; if (slot !== SW'(0)) begin failures++; $display("FAIL arst_hunt_slot: got %0d exp 0", slot); end
    checks++; if (qv_cnt - qv0 !== 0) begin failures++; $display("FAIL arst_no_pulse: got %0d exp 0", qv_cnt - qv0); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(1'b1, 1'b1);
    checks++; if (slot !== SW'(1)) begin failures++; $display("FAIL arst_first_edge_sync: got %0d exp 1", slot); end
    send_tail(4'b1011);
    idle(2);
    checks++; if (q !== 4'b1011) begin failures++; $display("FAIL arst_after_q: got %b exp 1011", q); end
  endtask

  task automatic test_hunt();
    int qv0, fe0, pe0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    qv0 = qv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    for (int i = 0; i < 10; i++) begin
      send(1'b0, 1'($urandom_range(0, 1)));
      checks++; if (slot !== SW'(0)) begin failures++; $display("FAIL hunt_slot[%0d]: got %0d exp 0", i, slot); end
    end
    checks++; if ((qv_cnt - qv0) + (fe_cnt - fe0) + (pe_cnt - pe0) !== 0) begin
      failures++; $display("FAIL hunt_no_pulses: got %0d exp 0", (qv_cnt - qv0) + (fe_cnt - fe0) + (pe_cnt - pe0));
    end
  endtask

`ifdef DEMUX_PARITY_EN
  task automatic test_parity();
    int qv0;
    send(1'b1, 1'b1);
    send_tail(4'b0101);
    idle(2);
    checks++; if (q !== 4'b0101) begin failures++; $display("FAIL par_good_q: got %b exp 0101", q); end
    qv0 = qv_cnt;
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    idle(1);
    checks++; if (par_err !== 1'b1) begin failures++; $display("FAIL par_err_pulse: got %b exp 1", par_err); end
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL par_no_qv: got %b exp 0", q_valid); end
    idle(1);
    checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL par_err_end: got %b exp 0", par_err); end
    checks++; if (q !== 4'b0101) begin failures++; $display("FAIL par_q_kept: got %b exp 0101", q); end
    checks++; if (slot !== SW'(0)) begin failures++; $display("FAIL par_slot: got %0d exp 0", slot); end
    checks++; if (qv_cnt - qv0 !== 0) begin failures++; $display("FAIL par_qv_count: got %0d exp 0", qv_cnt - qv0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_gap();
    test_frame_err();
    test_back_to_back();
    test_async_reset();
    test_hunt();
`ifdef DEMUX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
